// File: rtl/fcmp_seq.sv
// ---------------------------------------------------------------------------
// fcmp_seq -- sequential FP32 comparator (FEQ / FLT / FLE).
//
// Operands are captured on a valid/ready handshake. Their magnitudes are
// compared one byte per cycle, most significant byte first, and the compare
// stops at the first unequal byte. The result is held until the consumer
// takes it.
//
// Optional feature: define FCMP_NAN_CHECK_EN to detect NaN operands at
// capture. With it, a NaN skips the byte compare and raises invalid_o
// according to the RISC-V rules. Without it, NaNs are compared as plain
// sign-magnitude values and invalid_o is tied low.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  block can accept a request (IDLE)
//   a_i, b_i     FP32 operands
//   op_i         00 FEQ, 01 FLT, 10 FLE, 11 reserved (result 0)
//   rsp_valid_o  result available
//   rsp_ready_i  consumer takes the result
//   result_o     a op b, 0 while rsp_valid_o is low
//   invalid_o    invalid-operation flag, 0 while rsp_valid_o is low
//   busy_o       high in any state other than IDLE
// ---------------------------------------------------------------------------
module fcmp_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [1:0]  op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        result_o,
    output logic        invalid_o,
    output logic        busy_o
);

    localparam int unsigned W_DATA = 32;
    localparam logic [1:0]  OP_FEQ = 2'b00;
    localparam logic [1:0]  OP_FLT = 2'b01;
    localparam logic [1:0]  OP_FLE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [W_DATA-1:0]   r_a;
    logic [W_DATA-1:0]   r_b;
    logic [1:0]          r_op;
    logic [1:0]          r_idx;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_result;
    logic                r_busy;

    logic [W_DATA-1:0]   w_mag_a;
    logic [W_DATA-1:0]   w_mag_b;
    logic [7:0]          w_byte_a;
    logic [7:0]          w_byte_b;
    logic                w_byte_lt;
    logic                w_byte_gt;
    logic                w_done;
    logic                w_both_zero;
    logic                w_lt;
    logic                w_gt;
    logic                w_eq;
    logic                w_cmp_res;

    // Magnitudes with the sign bit cleared
    assign w_mag_a = {1'b0, r_a[30:0]};
    assign w_mag_b = {1'b0, r_b[30:0]};

    // Byte currently under comparison
    always_comb begin
        w_byte_a = 8'h00;
        w_byte_b = 8'h00;
        case (r_idx)
            2'd3: begin w_byte_a = w_mag_a[31:24]; w_byte_b = w_mag_b[31:24]; end
            2'd2: begin w_byte_a = w_mag_a[23:16]; w_byte_b = w_mag_b[23:16]; end
            2'd1: begin w_byte_a = w_mag_a[15:8];  w_byte_b = w_mag_b[15:8];  end
            default: begin w_byte_a = w_mag_a[7:0]; w_byte_b = w_mag_b[7:0]; end
        endcase
    end

    assign w_byte_lt   = (w_byte_a < w_byte_b);
    assign w_byte_gt   = (w_byte_a > w_byte_b);
    assign w_done      = w_byte_lt | w_byte_gt | (r_idx == 2'd0);
    assign w_both_zero = (r_a[30:0] == 31'd0) && (r_b[30:0] == 31'd0);

    // Sign resolution on top of the magnitude outcome
    always_comb begin
        w_lt = 1'b0;
        w_gt = 1'b0;
        w_eq = 1'b0;
        if (w_both_zero) begin
            w_eq = 1'b1;
        end else if (r_a[31] != r_b[31]) begin
            w_lt = r_a[31];
            w_gt = ~r_a[31];
        end else if (r_a[31]) begin
            // Both negative: larger magnitude is the smaller value
            w_lt = w_byte_gt;
            w_gt = w_byte_lt;
            w_eq = ~(w_byte_lt | w_byte_gt);
        end else begin
            w_lt = w_byte_lt;
            w_gt = w_byte_gt;
            w_eq = ~(w_byte_lt | w_byte_gt);
        end
    end

    always_comb begin
        w_cmp_res = 1'b0;
        case (r_op)
            OP_FEQ:  w_cmp_res = w_eq;
            OP_FLT:  w_cmp_res = w_lt;
            OP_FLE:  w_cmp_res = w_lt | w_eq;
            default: w_cmp_res = 1'b0;
        endcase
    end

`ifdef FCMP_NAN_CHECK_EN
    logic r_invalid;
    logic r_nan;
    logic r_snan;
    logic w_a_nan;
    logic w_b_nan;
    logic w_a_snan;
    logic w_b_snan;
    logic w_nan_invalid;

    assign w_a_nan  = (&a_i[30:23]) && (|a_i[22:0]);
    assign w_b_nan  = (&b_i[30:23]) && (|b_i[22:0]);
    assign w_a_snan = w_a_nan && ~a_i[22];
    assign w_b_snan = w_b_nan && ~b_i[22];

    // Ordered compares flag any NaN; equality flags only signaling NaNs
    always_comb begin
        w_nan_invalid = 1'b0;
        case (r_op)
            OP_FEQ:  w_nan_invalid = r_snan;
            OP_FLT:  w_nan_invalid = 1'b1;
            OP_FLE:  w_nan_invalid = 1'b1;
            default: w_nan_invalid = 1'b0;
        endcase
    end

    assign invalid_o = r_invalid;
`else
    assign invalid_o = 1'b0;
`endif

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 2'b00;
            r_idx       <= 2'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_result    <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FCMP_NAN_CHECK_EN
            r_invalid   <= 1'b0;
            r_nan       <= 1'b0;
            r_snan      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_a         <= a_i;
                        r_b         <= b_i;
                        r_op        <= op_i;
                        r_idx       <= 2'd3;
                        r_state     <= S_CMP;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef FCMP_NAN_CHECK_EN
                        r_nan       <= w_a_nan | w_b_nan;
                        r_snan      <= w_a_snan | w_b_snan;
`endif
                    end
                end
                S_CMP: begin
`ifdef FCMP_NAN_CHECK_EN
                    if (r_nan) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_result    <= 1'b0;
                        r_invalid   <= w_nan_invalid;
                    end else
`endif
                    if (w_done) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_result    <= w_cmp_res;
                    end else begin
                        r_idx       <= r_idx - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_result    <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
`ifdef FCMP_NAN_CHECK_EN
                        r_invalid   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_result    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign result_o    = r_result;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_fcmp_seq.sv
// ---------------------------------------------------------------------------
// tb_fcmp_seq -- directed testbench for fcmp_seq.
// Expected values are hand-computed from the FP32 operand encodings.
// ---------------------------------------------------------------------------
module tb_fcmp_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  op_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        result_o;
    logic        invalid_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        res;
        logic        inv;
        logic [2:0]  lat;
    } vec_t;

    vec_t cmp_vecs [12];
    vec_t nan_vecs [4];

    fcmp_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .result_o    (result_o),
        .invalid_o   (invalid_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issue one request, wait for the response, consume it.
    // Latency counts rising edges from the accept edge to rsp_valid_o high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         output logic res, output logic inv, output int lat);
        a_i = a; b_i = b; op_i = op; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 0;
        while (!rsp_valid_o && lat < 10) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = result_o;
        inv = invalid_o;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({req_ready_o, rsp_valid_o, result_o, invalid_o, busy_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_during: got rdy/vld/res/inv/busy=%b want 10000",
                     {req_ready_o, rsp_valid_o, result_o, invalid_o, busy_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_tests++;
        if ({req_ready_o, rsp_valid_o, result_o, invalid_o, busy_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_after: got rdy/vld/res/inv/busy=%b want 10000",
                     {req_ready_o, rsp_valid_o, result_o, invalid_o, busy_o});
        end
    endtask

    task automatic test_compare();
        logic res, inv;
        int   lat;
        cmp_vecs = '{
            '{32'h3F800000, 32'h40000000, 2'b01, 1'b1, 1'b0, 3'd1},
            '{32'h3F800001, 32'h3F800001, 2'b00, 1'b1, 1'b0, 3'd4},
            '{32'h3F800001, 32'h3F800000, 2'b00, 1'b0, 1'b0, 3'd4},
            '{32'h80000000, 32'h00000000, 2'b00, 1'b1, 1'b0, 3'd4},
            '{32'h80000000, 32'h00000000, 2'b01, 1'b0, 1'b0, 3'd4},
            '{32'h80000000, 32'h00000000, 2'b10, 1'b1, 1'b0, 3'd4},
            '{32'hC0000000, 32'hBF800000, 2'b01, 1'b1, 1'b0, 3'd1},
            '{32'hBF800000, 32'h3F800000, 2'b01, 1'b1, 1'b0, 3'd4},
            '{32'h3F800000, 32'h3F000000, 2'b10, 1'b0, 1'b0, 3'd2},
            '{32'h3F800000, 32'h3F800100, 2'b01, 1'b1, 1'b0, 3'd3},
            '{32'h3F800000, 32'h3F800000, 2'b11, 1'b0, 1'b0, 3'd4},
            '{32'hBF800000, 32'hBF800000, 2'b10, 1'b1, 1'b0, 3'd4}
        };
        for (int i = 0; i < 12; i++) begin
            do_op(cmp_vecs[i].a, cmp_vecs[i].b, cmp_vecs[i].op, res, inv, lat);
            n_tests++;
            if (res !== cmp_vecs[i].res) begin
                n_fail++;
                $display("FAIL cmp[%0d] result: got %b want %b", i, res, cmp_vecs[i].res);
            end
            n_tests++;
            if (inv !== cmp_vecs[i].inv) begin
                n_fail++;
                $display("FAIL cmp[%0d] invalid: got %b want %b", i, inv, cmp_vecs[i].inv);
            end
            n_tests++;
            if (lat !== int'(cmp_vecs[i].lat)) begin
                n_fail++;
                $display("FAIL cmp[%0d] latency: got %0d want %0d", i, lat, cmp_vecs[i].lat);
            end
        end
    endtask

    task automatic test_nan();
        logic res, inv;
        int   lat;
`ifdef FCMP_NAN_CHECK_EN
        nan_vecs = '{
            '{32'h7FC00000, 32'h3F800000, 2'b10, 1'b0, 1'b1, 3'd1},
            '{32'h7FC00000, 32'h3F800000, 2'b00, 1'b0, 1'b0, 3'd1},
            '{32'h7F800001, 32'h3F800000, 2'b00, 1'b0, 1'b1, 3'd1},
            '{32'h3F800000, 32'h7FC00000, 2'b01, 1'b0, 1'b1, 3'd1}
        };
`else
        nan_vecs = '{
            '{32'h7FC00000, 32'h3F800000, 2'b10, 1'b0, 1'b0, 3'd1},
            '{32'h7FC00000, 32'h3F800000, 2'b00, 1'b0, 1'b0, 3'd1},
            '{32'h7F800001, 32'h3F800000, 2'b00, 1'b0, 1'b0, 3'd1},
            '{32'h3F800000, 32'h7FC00000, 2'b01, 1'b1, 1'b0, 3'd1}
        };
`endif
        for (int i = 0; i < 4; i++) begin
            do_op(nan_vecs[i].a, nan_vecs[i].b, nan_vecs[i].op, res, inv, lat);
            n_tests++;
            if (res !== nan_vecs[i].res) begin
                n_fail++;
                $display("FAIL nan[%0d] result: got %b want %b", i, res, nan_vecs[i].res);
            end
            n_tests++;
            if (inv !== nan_vecs[i].inv) begin
                n_fail++;
                $display("FAIL nan[%0d] invalid: got %b want %b", i, inv, nan_vecs[i].inv);
            end
            n_tests++;
            if (lat !== int'(nan_vecs[i].lat)) begin
                n_fail++;
                $display("FAIL nan[%0d] latency: got %0d want %0d", i, lat, nan_vecs[i].lat);
            end
        end
    endtask

    task automatic test_backpressure();
        a_i = 32'h3F800000; b_i = 32'h40000000; op_i = 2'b01; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        // Response pending; offer a competing request that must be ignored
        a_i = 32'h40000000; b_i = 32'h3F800000; op_i = 2'b00; req_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({rsp_valid_o, result_o, invalid_o, req_ready_o, busy_o} !== 5'b11001) begin
                n_fail++;
                $display("FAIL stall[%0d]: got vld/res/inv/rdy/busy=%b want 11001", c,
                         {rsp_valid_o, result_o, invalid_o, req_ready_o, busy_o});
            end
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        n_tests++;
        if ({rsp_valid_o, result_o, invalid_o, req_ready_o, busy_o} !== 5'b00010) begin
            n_fail++;
            $display("FAIL stall_release: got vld/res/inv/rdy/busy=%b want 00010",
                     {rsp_valid_o, result_o, invalid_o, req_ready_o, busy_o});
        end
        @(posedge clk_i); #1;
        n_tests++;
        if ({busy_o, rsp_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_no_ghost: got busy/vld=%b want 00", {busy_o, rsp_valid_o});
        end
    endtask

    task automatic test_reset_mid_cmp();
        logic res, inv;
        int   lat;
        int   seen;
        a_i = 32'h3F800001; b_i = 32'h3F800001; op_i = 2'b00; req_valid_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_tests++;
        if ({busy_o, rsp_valid_o, req_ready_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL midcmp_busy: got busy/vld/rdy=%b want 100",
                     {busy_o, rsp_valid_o, req_ready_o});
        end
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid_o, result_o, invalid_o, busy_o, req_ready_o} !== 5'b00001) begin
            n_fail++;
            $display("FAIL midcmp_async_reset: got vld/res/inv/busy/rdy=%b want 00001",
                     {rsp_valid_o, result_o, invalid_o, busy_o, req_ready_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o || busy_o) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midcmp_no_response: got %0d active cycles want 0", seen);
        end
        do_op(32'h3F800000, 32'h40000000, 2'b01, res, inv, lat);
        n_tests++;
        if ({res, inv} !== 2'b10 || lat !== 1) begin
            n_fail++;
            $display("FAIL midcmp_recover: got res/inv=%b lat=%0d want 10 lat=1", {res, inv}, lat);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        a_i         = 32'h0;
        b_i         = 32'h0;
        op_i        = 2'b00;
        test_reset();
        test_compare();
        test_nan();
        test_backpressure();
        test_reset_mid_cmp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
